divisor_frecuencia_multi: RTL and testbench

- Parametrised successor to the single-rate clock divider in the RELOJ design.
- A prescaler turns the system clock into a base tick (default 1 Hz). Further channels cascade, each dividing the previous channel's tick by a per-stage ratio (default chain is seconds, then minutes).
- Per channel it emits a one-cycle tick strobe, plus an optional 50%-duty square wave.
- Adds run-time enable and synchronous clear, which the previous divider lacked; feeds the time-keeping counters and display refresh.

---
 rtl/reloj_pkg.sv | 21 ++
 rtl/divisor_frecuencia_multi_div_stage.sv | 33 +++
 rtl/divisor_frecuencia_multi.sv | 152 +++++++++++++++
 tb/tb_divisor_frecuencia_multi.sv | 118 +++++++++++
 4 files changed

// File: rtl/reloj_pkg.sv
// reloj_pkg: shared constants and helpers for the RELOJ clock-division slice.
//   MAX_CH / STAGE_W   : channel limit and width of one packed ratio field
//   SEG_POR_MIN, ...   : default cascade ratios (seconds, minutes, hours)
//   div_field(vec, i)  : extracts ratio field i from a packed STAGE_DIV vector
package reloj_pkg;

   localparam int unsigned MAX_CH  = 8;
   localparam int unsigned STAGE_W = 8;

   localparam int unsigned SEG_POR_MIN   = 60;
   localparam int unsigned MIN_POR_HORA  = 60;
   localparam int unsigned HORAS_POR_DIA = 24;

   function automatic logic [STAGE_W-1:0] div_field(
      input logic [STAGE_W*MAX_CH-1:0] vec,
      input int unsigned               i
   );
      return vec[STAGE_W*i +: STAGE_W];
   endfunction

endpackage

// File: rtl/divisor_frecuencia_multi_div_stage.sv
// div_stage: modulo-N counter used for the prescaler and every cascade channel.
//   clock, rst_n : rising-edge clock, asynchronous active-low reset
//   inc          : advance the counter on this edge
//   clr          : synchronous clear, wins over inc
//   count        : current count, 0..N-1
//   carry        : combinational wrap indication (inc && count == N-1)
module div_stage #(
   parameter int unsigned N = 2,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         carry
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   assign carry = inc && (count == LAST);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr || carry) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/divisor_frecuencia_multi.sv
// divisor_frecuencia_multi: prescaler plus cascaded divide-by-D channels.
//   clock : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : count enable, low holds every counter
//   clr   : synchronous clear of all counters, tick and sq
//   tick  : one-cycle registered strobe per channel
//   sq    : registered square wave per channel when DIV_SQUARE_OUT_EN is
//           defined, constant 0 otherwise
// Channel 0 ticks every CLK_HZ/BASE_HZ enabled cycles; channel i divides
// channel i-1 by field i of STAGE_DIV. Carries ripple combinationally, so
// coinciding ticks on several channels assert in the same cycle.
module divisor_frecuencia_multi
   import reloj_pkg::*;
#(
   parameter int unsigned                  CLK_HZ    = 50000000,
   parameter int unsigned                  BASE_HZ   = 1,
   parameter int unsigned                  NUM_CH    = 3,
   parameter logic [STAGE_W*MAX_CH-1:0]    STAGE_DIV = 64'h3C3C00
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   localparam int unsigned PRE = CLK_HZ / BASE_HZ;
   localparam int unsigned PW  = (PRE < 2) ? 1 : $clog2(PRE);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $fatal(1, "NUM_CH must be within 1..8");
   end
   if (PRE < 2) begin : g_bad_pre
      $fatal(1, "CLK_HZ/BASE_HZ must be at least 2");
   end

   logic [NUM_CH-1:0] carry;
   logic [PW-1:0]     p;
   logic              pre_cy;

   div_stage #(
      .N (PRE),
      .W (PW)
   ) u_pre (
      .clock (clock),
      .rst_n (rst_n),
      .inc   (en),
      .clr   (clr),
      .count (p),
      .carry (pre_cy)
   );

   assign carry[0] = pre_cy;

`ifdef DIV_SQUARE_OUT_EN
   logic [NUM_CH-1:0] sq_nxt;
   logic [PW-1:0]     p_nxt;

   // Square outputs are decoded from the counters' next values so sq lines
   // up with the registered tick instead of trailing it by a cycle.
   always_comb begin
      p_nxt = p;
      if (clr || pre_cy) begin
         p_nxt = '0;
      end else if (en) begin
         p_nxt = p + PW'(1);
      end
   end

   assign sq_nxt[0] = (p_nxt >= PW'(PRE / 2));
`else
   logic unused_p;
   assign unused_p = ^p;
`endif

   for (genvar i = 1; i < NUM_CH; i++) begin : g_ch
      localparam int unsigned D = div_field(STAGE_DIV, i);

      if (D < 2) begin : g_bad_div
         $fatal(1, "STAGE_DIV ratio fields 1..NUM_CH-1 must be at least 2");
      end

      logic               cy_in;
      logic               cy;
      logic [STAGE_W-1:0] c;

      // Each link of the carry chain is its own net so the ripple does not
      // loop back through a single vector.
      if (i == 1) begin : g_first
         assign cy_in = pre_cy;
      end else begin : g_next
         assign cy_in = g_ch[i-1].cy;
      end

      div_stage #(
         .N (D),
         .W (STAGE_W)
      ) u_stage (
         .clock (clock),
         .rst_n (rst_n),
         .inc   (cy_in),
         .clr   (clr),
         .count (c),
         .carry (cy)
      );

      assign carry[i] = cy;

`ifdef DIV_SQUARE_OUT_EN
      logic [STAGE_W-1:0] c_nxt;

      always_comb begin
         c_nxt = c;
         if (clr || cy) begin
            c_nxt = '0;
         end else if (cy_in) begin
            c_nxt = c + STAGE_W'(1);
         end
      end

      assign sq_nxt[i] = (c_nxt >= STAGE_W'(D / 2));
`else
      logic unused_c;
      assign unused_c = ^c;
`endif
   end

   // clr discards any wrap landing on the same edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
      end else if (clr) begin
         tick <= '0;
      end else begin
         tick <= carry;
      end
   end

`ifdef DIV_SQUARE_OUT_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sq <= '0;
      end else begin
         sq <= sq_nxt;
      end
   end
`else
   assign sq = '0;
`endif

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// tb_divisor_frecuencia_multi: directed bench for divisor_frecuencia_multi
// with CLK_HZ=10, BASE_HZ=1, NUM_CH=3, D1=3, D2=2 (periods 10 / 30 / 60).
module tb_divisor_frecuencia_multi;

   localparam int unsigned NCH = 3;

   logic           clock = 1'b0;
   logic           rst_n;
   logic           en;
   logic           clr;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned e        = 0;   // enabled edges since reset/clear

   always #5 clock = ~clock;

   divisor_frecuencia_multi #(
      .CLK_HZ    (10),
      .BASE_HZ   (1),
      .NUM_CH    (NCH),
      .STAGE_DIV (64'h020300)
   ) dut (
      .clock (clock),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .tick  (tick),
      .sq    (sq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at e=%0d t=%0t", tag, got, exp, e, $time);
      end
   endtask

   // p = n%10 (high from 5), c1 = (n/10)%3 (high from 1), c2 = (n/30)%2 (high from 1)
   function automatic logic [NCH-1:0] exp_sq(input int unsigned n);
`ifdef DIV_SQUARE_OUT_EN
      return {((n / 30) % 2) >= 1, ((n / 10) % 3) >= 1, (n % 10) >= 5};
`else
      return '0;
`endif
   endfunction

   // Apply inputs for one edge, then sample #1 after it.
   task automatic cyc(input logic en_v, input logic clr_v);
      logic [NCH-1:0] et;
      en  = en_v;
      clr = clr_v;
      @(posedge clock);
      #1;
      if (clr_v) begin
         e  = 0;
         et = '0;
      end else if (en_v) begin
         e++;
         et = {(e % 60) == 0, (e % 30) == 0, (e % 10) == 0};
      end else begin
         et = '0;
      end
      chk("tick", tick, et);
      chk("sq", sq, exp_sq(e));
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) cyc(1'b1, 1'b0);
   endtask

   initial begin
      en    = 1'b0;
      clr   = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_tick", tick, '0);
      chk("reset_sq", sq, '0);
      #9 rst_n = 1'b1;

      // Free run: tick[0] at 10,20..; tick[1] at 30,60..; tick[2] at 60,120
      run(120);

      // Hold for 5 cycles with p at 7
      run(7);
      for (int unsigned k = 0; k < 5; k++) cyc(1'b0, 1'b0);
      run(23);

      // Clear on the edge where p==9 and c1==2 (e=179): wrap is discarded
      run(29);
      chk("pre_clr_e", e, 179);
      cyc(1'b1, 1'b1);
      run(60);

      // Clear while disabled
      run(4);
      cyc(1'b0, 1'b1);
      run(10);
      chk("pre_rst_tick", tick, 3'b001);

      // Asynchronous reset between edges, then identical restart
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_tick", tick, '0);
      chk("async_rst_sq", sq, '0);
      #1 rst_n = 1'b1;
      e = 0;
      run(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
